alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state updates on rising clk.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 start  in  1  operation request; sampled only when ready=1.
REQ-005 ready  out  1  high in IDLE only.
REQ-006 fs_in  in  16  function-select code, same encoding as the function unit.
REQ-007 byte_op  in  1  byte operation; wb_en  in  1  write result (0 for CMP/BIT).
REQ-008 src_is_mem, dst_is_mem  in  1 each  operand location; src_val, dst_val  in  16  register operand values.
REQ-009 src_addr, dst_addr  in  16  memory operand byte addresses.
REQ-010 mem_req, mem_we  out  1 each; mem_addr, mem_wdata  out  16; mem_be  out  2; mem_rdata  in  16; mem_ack  in  1.
REQ-011 fu_fs, fu_src, fu_dst  out  16  function-unit drive; fu_result  in  16; fu_zvnc  in  4  flags from function unit.
REQ-012 sr_zvnc  in  4  current Z,V,N,C; sr_we  out  1; sr_zvnc_out  out  4.
REQ-013 reg_we  out  1; reg_wdata  out  16  register writeback; done  out  1  one-cycle completion pulse.

Function
REQ-014 SHALL implement states IDLE, SRC_RD, DST_RD, EXEC, WR, DONE.
REQ-015 IDLE + start: capture all inputs, then go to SRC_RD if src_is_mem, else DST_RD if dst_is_mem, else EXEC.
REQ-016 start while ready=0 SHALL be ignored and not queued.
REQ-017 SRC_RD/DST_RD: hold mem_req=1, mem_we=0, and mem_addr stable until mem_ack; on ack, capture mem_rdata.
REQ-018 SRC_RD exit: go to DST_RD if dst_is_mem, else EXEC.
REQ-019 mem_ack outside SRC_RD/DST_RD/WR SHALL be ignored.
REQ-020 Read byte lane: addr[0]=0 selects rdata[7:0]; addr[0]=1 selects rdata[15:8]; result zero-extended to 16 bits.
REQ-021 Word accesses force mem_addr[0]=0.
REQ-022 EXEC (exactly 1 cycle): drive fu_fs, fu_src, fu_dst, and pass sr_zvnc to the function unit combinationally; latch fu_result and fu_zvnc.
REQ-023 EXEC exit: go to WR if wb_en & dst_is_mem, else DONE.
REQ-024 WR: hold mem_req=1, mem_we=1 until mem_ack, with mem_addr=dst_addr.
REQ-025 WR data: word gives mem_be=2'b11, mem_wdata=result; byte gives mem_wdata={res[7:0],res[7:0]}, mem_be=2'b01 (addr[0]=0) or 2'b10 (addr[0]=1).
REQ-026 DONE (1 cycle): done=1 and sr_we=1 with latched flags.
REQ-027 DONE: reg_we=1 iff wb_en & ~dst_is_mem, with reg_wdata=latched result (byte ops: high byte 0); then go to IDLE.
REQ-028 Latency for zero wait states, start accepted at edge T: reg-reg done at T+2; each memory access adds 1+waits cycles.
REQ-029 mem_req SHALL never be asserted in IDLE, EXEC, or DONE; at most one outstanding access.

Reset
REQ-030 rst SHALL force IDLE at the next edge from any state, including mid-handshake, without completing the pending access.
REQ-031 Reset values: ready=1; mem_req, mem_we, sr_we, reg_we, done = 0; mem_be=0; all data/address outputs and latches = 0; fu_fs = 0.

Structure
REQ-032 FS codes and the state encoding SHALL live in the shared MSP430 parameter package used by the function unit.
REQ-033 Byte-lane select/replicate logic (REQ-020, REQ-025) SHALL be one sub-module: byte_lane.
REQ-034 The function unit SHALL be external, not instantiated inside alu_sequencer.

Verification
REQ-035 ADD reg-reg, src=0x7FFF, dst=0x0001, sr=0 -> done at T+2, reg_wdata=0x8000, sr_zvnc_out: N=1, V=1, Z=0, C=0.
REQ-036 ADD.B, src mem @0x0201 (rdata 0x3400, ack after 2 waits), dst reg 0x0010 -> fu_src=0x0034, reg_wdata=0x0044.
REQ-037 CMP, src=0x0005, dst=0x0005, wb_en=0 -> reg_we=0, no WR, sr_we=1, Z=1, C=1.
REQ-038 MOV.B, dst mem @0x0300, result 0x00AB -> mem_we=1, mem_be=2'b01, mem_wdata=0xABAB, mem_addr held until ack.
REQ-039 rst during DST_RD with mem_ack never asserted -> next cycle IDLE, ready=1, mem_req=0, no done.
REQ-040 start pulsed during SRC_RD -> ignored; exactly one done observed.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared MSP430 parameters: function-select codes used by the function unit and
// the state encoding of the ALU sequencer.
package alu_sequencer_pkg;

    localparam logic [15:0] FS_MOV = 16'h0001;
    localparam logic [15:0] FS_ADD = 16'h0002;
    localparam logic [15:0] FS_SUB = 16'h0004;
    localparam logic [15:0] FS_CMP = 16'h0008;
    localparam logic [15:0] FS_AND = 16'h0010;
    localparam logic [15:0] FS_XOR = 16'h0020;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SRC_RD = 3'd1,
        ST_DST_RD = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WR     = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_t;

    // Word accesses are always aligned; byte accesses keep the lane bit.
    function automatic logic [15:0] bus_addr(input logic [15:0] addr, input logic byte_op);
        return byte_op ? addr : {addr[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/alu_sequencer_byte_lane.sv
// Byte-lane steering between the 16-bit memory bus and operand/result values:
// read lane select with zero extension, write replication and byte enables.
module byte_lane (
    input  logic        byte_op,
    input  logic        addr_lsb,
    input  logic [15:0] rdata,
    input  logic [15:0] wres,
    output logic [15:0] rd_val,
    output logic [15:0] wdata,
    output logic [1:0]  be
);

    assign rd_val = !byte_op ? rdata :
                    addr_lsb ? {8'h00, rdata[15:8]} : {8'h00, rdata[7:0]};

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        assign wdata[8*gi +: 8] = byte_op ? wres[7:0] : wres[8*gi +: 8];
        assign be[gi]           = byte_op ? (addr_lsb == 1'(gi)) : 1'b1;
    end

endmodule

// File: rtl/alu_sequencer.sv
// ALU instruction sequencer: fetches memory operands, drives an external function
// unit for one cycle, then writes the result to memory or the register file.
module alu_sequencer
    import alu_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        ready,
    input  logic [15:0] fs_in,
    input  logic        byte_op,
    input  logic        wb_en,
    input  logic        src_is_mem,
    input  logic        dst_is_mem,
    input  logic [15:0] src_val,
    input  logic [15:0] dst_val,
    input  logic [15:0] src_addr,
    input  logic [15:0] dst_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_be,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] fu_fs,
    output logic [15:0] fu_src,
    output logic [15:0] fu_dst,
    input  logic [15:0] fu_result,
    input  logic [3:0]  fu_zvnc,
    input  logic [3:0]  sr_zvnc,
    output logic        sr_we,
    output logic [3:0]  sr_zvnc_out,
    output logic        reg_we,
    output logic [15:0] reg_wdata,
    output logic        done
);

    seq_state_t  state_q, state_d;
    logic [15:0] fs_q, fs_d;
    logic        byte_q, byte_d, wb_q, wb_d, smem_q, smem_d, dmem_q, dmem_d;
    logic [15:0] src_q, src_d, dst_q, dst_d;
    logic [15:0] saddr_q, saddr_d, daddr_q, daddr_d;
    logic [15:0] res_q, res_d;
    logic [3:0]  flags_q, flags_d;
    logic [15:0] cur_addr, lane_rd, lane_wdata;
    logic [1:0]  lane_be;
    logic        in_read;

    assign in_read  = (state_q == ST_SRC_RD) || (state_q == ST_DST_RD);
    assign cur_addr = (state_q == ST_SRC_RD) ? saddr_q : daddr_q;

    byte_lane u_byte_lane (
        .byte_op (byte_q),
        .addr_lsb(cur_addr[0]),
        .rdata   (mem_rdata),
        .wres    (res_q),
        .rd_val  (lane_rd),
        .wdata   (lane_wdata),
        .be      (lane_be)
    );

    always_comb begin
        state_d = state_q;
        fs_d    = fs_q;
        byte_d  = byte_q;
        wb_d    = wb_q;
        smem_d  = smem_q;
        dmem_d  = dmem_q;
        src_d   = src_q;
        dst_d   = dst_q;
        saddr_d = saddr_q;
        daddr_d = daddr_q;
        res_d   = res_q;
        flags_d = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    fs_d    = fs_in;
                    byte_d  = byte_op;
                    wb_d    = wb_en;
                    smem_d  = src_is_mem;
                    dmem_d  = dst_is_mem;
                    src_d   = src_val;
                    dst_d   = dst_val;
                    saddr_d = src_addr;
                    daddr_d = dst_addr;
                    flags_d = sr_zvnc;
                    state_d = src_is_mem ? ST_SRC_RD : (dst_is_mem ? ST_DST_RD : ST_EXEC);
                end
            end
            ST_SRC_RD: begin
                if (mem_ack) begin
                    src_d   = lane_rd;
                    state_d = dmem_q ? ST_DST_RD : ST_EXEC;
                end
            end
            ST_DST_RD: begin
                if (mem_ack) begin
                    dst_d   = lane_rd;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d   = fu_result;
                flags_d = fu_zvnc;
                state_d = (wb_q && dmem_q) ? ST_WR : ST_DONE;
            end
            ST_WR: begin
                if (mem_ack) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            fs_q    <= '0;
            byte_q  <= 1'b0;
            wb_q    <= 1'b0;
            smem_q  <= 1'b0;
            dmem_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            saddr_q <= '0;
            daddr_q <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            fs_q    <= fs_d;
            byte_q  <= byte_d;
            wb_q    <= wb_d;
            smem_q  <= smem_d;
            dmem_q  <= dmem_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            saddr_q <= saddr_d;
            daddr_q <= daddr_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    // Outputs decode only from state and latched values, so they never glitch on inputs.
    assign ready       = (state_q == ST_IDLE);
    assign mem_req     = in_read || (state_q == ST_WR);
    assign mem_we      = (state_q == ST_WR);
    assign mem_addr    = mem_req ? bus_addr(cur_addr, byte_q) : 16'h0000;
    assign mem_be      = mem_we ? lane_be : 2'b00;
    assign mem_wdata   = mem_we ? lane_wdata : 16'h0000;
    assign fu_fs       = fs_q;
    assign fu_src      = src_q;
    assign fu_dst      = dst_q;
    assign done        = (state_q == ST_DONE);
    assign sr_we       = done;
    assign sr_zvnc_out = flags_q;
    assign reg_we      = done && wb_q && !dmem_q;
    assign reg_wdata   = byte_q ? {8'h00, res_q[7:0]} : res_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural function unit and memory
// with random wait states, directed scenarios followed by random operations.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    typedef struct {
        logic [15:0] fs;
        bit          byte_op, wb, smem, dmem, poke;
        logic [15:0] sv, dv, sa, da;
        logic [3:0]  sr;
        int          waits;
    } op_t;

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } acc_t;

    typedef struct {
        int          cycles;
        logic [15:0] fu_src, reg_wdata;
        logic        reg_we, sr_we;
        logic [3:0]  flags;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst, start, ready, byte_op, wb_en, src_is_mem, dst_is_mem;
    logic [15:0] fs_in, src_val, dst_val, src_addr, dst_addr;
    logic        mem_req, mem_we, mem_ack, sr_we, reg_we, done;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, fu_fs, fu_src, fu_dst, fu_result, reg_wdata;
    logic [1:0]  mem_be;
    logic [3:0]  fu_zvnc, sr_zvnc, sr_zvnc_out;

    int          checks = 0, failures = 0;
    logic [15:0] mem_model [0:1023];
    acc_t        acc_q[$];
    int          force_waits = -1, wait_sum = 0, wait_cnt = -1, addr_unstable = 0;
    bit          no_ack = 0, spur_en = 0, cur_byte = 0;
    logic [15:0] acc_addr0 = '0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready), .fs_in(fs_in),
        .byte_op(byte_op), .wb_en(wb_en), .src_is_mem(src_is_mem), .dst_is_mem(dst_is_mem),
        .src_val(src_val), .dst_val(dst_val), .src_addr(src_addr), .dst_addr(dst_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .fu_fs(fu_fs), .fu_src(fu_src), .fu_dst(fu_dst), .fu_result(fu_result),
        .fu_zvnc(fu_zvnc), .sr_zvnc(sr_zvnc), .sr_we(sr_we), .sr_zvnc_out(sr_zvnc_out),
        .reg_we(reg_we), .reg_wdata(reg_wdata), .done(done)
    );

    // MSP430-style arithmetic on 8- or 16-bit operands; returns {result, Z, V, N, C}.
    function automatic logic [19:0] fu_calc(input logic [15:0] fs, input logic [15:0] s,
                                            input logic [15:0] d, input bit b, input logic [3:0] sr);
        int unsigned mask, msb, a, x, r;
        bit z, v, n, c;
        mask = b ? 32'hFF : 32'hFFFF;
        msb  = b ? 32'h80 : 32'h8000;
        a = 32'(s) & mask;
        x = 32'(d) & mask;
        {z, v, n, c} = sr;
        r = 0;
        case (fs)
            FS_MOV: r = a;
            FS_ADD: begin
                r = x + a; c = (r > mask); r = r & mask;
                v = (((a ^ r) & (x ^ r) & msb) != 0);
            end
            FS_SUB, FS_CMP: begin
                r = x + (~a & mask) + 1; c = (r > mask); r = r & mask;
                v = (((x ^ a) & (x ^ r) & msb) != 0);
            end
            FS_AND: begin r = x & a; c = (r != 0); v = 1'b0; end
            FS_XOR: begin r = x ^ a; c = (r != 0); v = ((a & x & msb) != 0); end
            default: r = 0;
        endcase
        if (fs != FS_MOV) begin
            z = (r == 0);
            n = ((r & msb) != 0);
        end
        return {r[15:0], z, v, n, c};
    endfunction

    assign {fu_result, fu_zvnc} = fu_calc(fu_fs, fu_src, fu_dst, cur_byte, sr_zvnc);

    function automatic logic [15:0] ref_rd(input logic [15:0] a, input bit b);
        logic [15:0] w;
        w = mem_model[a[10:1]];
        if (!b) return w;
        return a[0] ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory responder: random or forced wait states, optional stray acks while idle.
    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
                wait_cnt = -1;
            end
            if (rst || no_ack || !mem_req) begin
                wait_cnt = -1;
                if (spur_en && !rst && !mem_req && $urandom_range(0, 3) == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = 16'($urandom);
                end
            end else begin
                if (wait_cnt < 0) begin
                    wait_cnt = (force_waits >= 0) ? force_waits : int'($urandom_range(0, 3));
                    wait_sum += wait_cnt;
                    acc_addr0 = mem_addr;
                end
                if (mem_addr !== acc_addr0) addr_unstable++;
                if (wait_cnt == 0) begin
                    mem_ack = 1'b1;
                    acc_q.push_back('{mem_we, mem_addr, mem_be, mem_wdata});
                    if (mem_we) begin
                        if (mem_be[0]) mem_model[mem_addr[10:1]][7:0]  = mem_wdata[7:0];
                        if (mem_be[1]) mem_model[mem_addr[10:1]][15:8] = mem_wdata[15:8];
                    end else begin
                        mem_rdata = mem_model[mem_addr[10:1]];
                    end
                end else begin
                    wait_cnt--;
                    mem_rdata = 16'($urandom);
                end
            end
        end
    end

    task automatic run_op(input op_t op, input string tag, output obs_t ob);
        logic [15:0] s_op, d_op, res, exp_wd;
        logic [3:0]  fl;
        logic [19:0] fr;
        acc_t        exp_q[$];
        int          exec_cnt, req_bad;
        bit          got_done, poked, exp_reg_we, exec_now;
        logic [15:0] ofs, odst;

        s_op = op.smem ? ref_rd(op.sa, op.byte_op) : op.sv;
        d_op = op.dmem ? ref_rd(op.da, op.byte_op) : op.dv;
        fr = fu_calc(op.fs, s_op, d_op, op.byte_op, op.sr);
        res = fr[19:4];
        fl = fr[3:0];
        exp_reg_we = op.wb && !op.dmem;
        exp_wd = op.byte_op ? {8'h00, res[7:0]} : res;
        if (op.smem) exp_q.push_back('{1'b0, op.byte_op ? op.sa : (op.sa & 16'hFFFE), 2'b00, 16'h0000});
        if (op.dmem) exp_q.push_back('{1'b0, op.byte_op ? op.da : (op.da & 16'hFFFE), 2'b00, 16'h0000});
        if (op.dmem && op.wb)
            exp_q.push_back('{1'b1, op.byte_op ? op.da : (op.da & 16'hFFFE),
                              op.byte_op ? (op.da[0] ? 2'b10 : 2'b01) : 2'b11,
                              op.byte_op ? {res[7:0], res[7:0]} : res});

        acc_q.delete();
        wait_sum = 0;
        addr_unstable = 0;
        force_waits = op.waits;
        cur_byte = op.byte_op;
        sr_zvnc = op.sr;
        fs_in = op.fs; byte_op = op.byte_op; wb_en = op.wb;
        src_is_mem = op.smem; dst_is_mem = op.dmem;
        src_val = op.sv; dst_val = op.dv; src_addr = op.sa; dst_addr = op.da;
        start = 1'b1;
        ob = '{0, 16'h0, 16'h0, 1'b0, 1'b0, 4'h0};
        ofs = '0; odst = '0;
        exec_cnt = 0; req_bad = 0; got_done = 0; poked = 0;
        while (!got_done && ob.cycles < 100) begin
            @(negedge clk);
            ob.cycles++;
            start = 1'b0;
            if (ob.cycles == 1) begin
                // Inputs must have been captured at acceptance; scramble them now.
                fs_in = 16'($urandom); src_val = 16'($urandom); dst_val = 16'($urandom);
                src_addr = 16'($urandom); dst_addr = 16'($urandom);
                byte_op = 1'($urandom); wb_en = 1'($urandom);
                src_is_mem = 1'($urandom); dst_is_mem = 1'($urandom);
            end
            if (op.poke && !poked && mem_req && !mem_we) begin
                start = 1'b1;
                poked = 1;
            end
            exec_now = !ready && !mem_req && !done;
            if (exec_now) begin
                exec_cnt++;
                ofs = fu_fs; ob.fu_src = fu_src; odst = fu_dst;
            end
            if ((ready || done || exec_now) && mem_req) req_bad++;
            if (done) begin
                got_done = 1;
                ob.reg_we = reg_we; ob.reg_wdata = reg_wdata;
                ob.sr_we = sr_we; ob.flags = sr_zvnc_out;
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 32'(got_done), 1);
        chk({tag, "_latency"}, ob.cycles, 2 + exp_q.size() + wait_sum);
        chk({tag, "_exec_cycles"}, exec_cnt, 1);
        chk({tag, "_fu_fs"}, ofs, op.fs);
        chk({tag, "_fu_src"}, ob.fu_src, s_op);
        chk({tag, "_fu_dst"}, odst, d_op);
        chk({tag, "_reg_we"}, 32'(ob.reg_we), 32'(exp_reg_we));
        if (exp_reg_we) chk({tag, "_reg_wdata"}, ob.reg_wdata, exp_wd);
        chk({tag, "_sr_we"}, 32'(ob.sr_we), 1);
        chk({tag, "_flags"}, ob.flags, fl);
        chk({tag, "_req_outside_access"}, req_bad, 0);
        chk({tag, "_addr_unstable"}, addr_unstable, 0);
        chk({tag, "_access_count"}, acc_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < acc_q.size(); k++) begin
            chk({tag, "_acc_we"}, 32'(acc_q[k].we), 32'(exp_q[k].we));
            chk({tag, "_acc_addr"}, acc_q[k].addr, exp_q[k].addr);
            if (exp_q[k].we) begin
                chk({tag, "_acc_be"}, acc_q[k].be, exp_q[k].be);
                chk({tag, "_acc_wdata"}, acc_q[k].wdata, exp_q[k].wdata);
            end
        end
        @(negedge clk);
        chk({tag, "_idle_after_done"}, {ready, done}, 2'b10);
        @(negedge clk);
        chk({tag, "_no_second_done"}, {ready, done}, 2'b10);
        $display("op %s fs=%h byte=%0d smem=%0d dmem=%0d wb=%0d res=%h flags=%b cycles=%0d",
                 tag, op.fs, op.byte_op, op.smem, op.dmem, op.wb, res, fl, ob.cycles);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        op_t         op;
        obs_t        ob;
        logic [15:0] fs_tab [0:5];
        int          cyc, extra_done;

        fs_tab[0] = FS_MOV; fs_tab[1] = FS_ADD; fs_tab[2] = FS_SUB;
        fs_tab[3] = FS_CMP; fs_tab[4] = FS_AND; fs_tab[5] = FS_XOR;
        rst = 1'b1; start = 1'b0; fs_in = '0; byte_op = 0; wb_en = 0;
        src_is_mem = 0; dst_is_mem = 0; src_val = '0; dst_val = '0;
        src_addr = '0; dst_addr = '0; sr_zvnc = '0;
        for (int i = 0; i < 1024; i++) mem_model[i] = 16'($urandom);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_ready", 32'(ready), 1);
        chk("rst_strobes", {mem_req, mem_we, sr_we, reg_we, done}, 5'b00000);
        chk("rst_mem_be", mem_be, 2'b00);
        chk("rst_mem_addr_wdata", {mem_addr, mem_wdata}, 32'h0);
        chk("rst_fu_fs", fu_fs, 16'h0);
        chk("rst_fu_operands", {fu_src, fu_dst}, 32'h0);
        chk("rst_reg_wdata_flags", {reg_wdata, sr_zvnc_out}, 20'h0);

        op = '{fs: FS_ADD, byte_op: 0, wb: 1, smem: 0, dmem: 0, poke: 0, sv: 16'h7FFF,
               dv: 16'h0001, sa: 16'h0, da: 16'h0, sr: 4'h0, waits: -1};
        run_op(op, "add_regreg", ob);
        chk("add_regreg_lat2", ob.cycles, 2);
        chk("add_regreg_wdata", ob.reg_wdata, 16'h8000);
        chk("add_regreg_zvnc", ob.flags, 4'b0110);

        mem_model[16'h0201 >> 1] = 16'h3400;
        op = '{fs: FS_ADD, byte_op: 1, wb: 1, smem: 1, dmem: 0, poke: 0, sv: 16'h0,
               dv: 16'h0010, sa: 16'h0201, da: 16'h0, sr: 4'h0, waits: 2};
        run_op(op, "addb_srcmem", ob);
        chk("addb_srcmem_fu_src", ob.fu_src, 16'h0034);
        chk("addb_srcmem_wdata", ob.reg_wdata, 16'h0044);
        chk("addb_srcmem_lat", ob.cycles, 5);

        op = '{fs: FS_CMP, byte_op: 0, wb: 0, smem: 0, dmem: 0, poke: 0, sv: 16'h0005,
               dv: 16'h0005, sa: 16'h0, da: 16'h0, sr: 4'h0, waits: -1};
        run_op(op, "cmp_equal", ob);
        chk("cmp_equal_reg_we", 32'(ob.reg_we), 0);
        chk("cmp_equal_sr_we", 32'(ob.sr_we), 1);
        chk("cmp_equal_z_c", {ob.flags[3], ob.flags[0]}, 2'b11);

        op = '{fs: FS_MOV, byte_op: 1, wb: 1, smem: 0, dmem: 1, poke: 0, sv: 16'h12AB,
               dv: 16'h0, sa: 16'h0, da: 16'h0300, sr: 4'h0, waits: 3};
        run_op(op, "movb_dstmem", ob);
        chk("movb_dstmem_n_acc", acc_q.size(), 2);
        if (acc_q.size() == 2) begin
            chk("movb_dstmem_we", 32'(acc_q[1].we), 1);
            chk("movb_dstmem_be", acc_q[1].be, 2'b01);
            chk("movb_dstmem_wdata", acc_q[1].wdata, 16'hABAB);
            chk("movb_dstmem_addr", acc_q[1].addr, 16'h0300);
        end

        op = '{fs: FS_ADD, byte_op: 0, wb: 1, smem: 1, dmem: 1, poke: 1, sv: 16'h0,
               dv: 16'h0, sa: 16'h0040, da: 16'h0082, sr: 4'h0, waits: 1};
        run_op(op, "start_in_srcrd", ob);

        // Reset while the destination read is stalled.
        op = '{fs: FS_ADD, byte_op: 0, wb: 1, smem: 0, dmem: 1, poke: 0, sv: 16'h1111,
               dv: 16'h0, sa: 16'h0, da: 16'h0100, sr: 4'h0, waits: -1};
        no_ack = 1;
        fs_in = op.fs; byte_op = 0; wb_en = 1; src_is_mem = 0; dst_is_mem = 1;
        src_val = op.sv; dst_addr = op.da; start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end while (!(mem_req && !mem_we && !ready) && cyc < 20);
        chk("rstmid_reached_dstrd", 32'(mem_req), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_idle", {ready, mem_req, done}, 3'b100);
        chk("rstmid_latches", {mem_addr, fu_src}, 32'h0);
        no_ack = 0;
        extra_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || mem_req) extra_done++;
        end
        chk("rstmid_no_done", extra_done, 0);

        spur_en = 1;
        for (int t = 0; t < 40; t++) begin
            op.fs      = fs_tab[$urandom_range(0, 5)];
            op.byte_op = 1'($urandom);
            op.smem    = 1'($urandom);
            op.dmem    = 1'($urandom);
            op.wb      = (op.fs == FS_CMP) ? 1'b0 : ($urandom_range(0, 5) != 0);
            op.poke    = ($urandom_range(0, 3) == 0);
            op.sv      = 16'($urandom);
            op.dv      = 16'($urandom);
            op.sa      = 16'($urandom_range(0, 2047));
            op.da      = 16'($urandom_range(0, 2047));
            op.sr      = 4'($urandom);
            op.waits   = -1;
            run_op(op, $sformatf("rand%0d", t), ob);
        end
        spur_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
